// File: rtl/vga_word_prefetch.sv
// Frame-buffer prefetch: streams FRAME_WORDS SRAM words from BASE_ADDR into a small FIFO for the VGA pixel stage.
// Optional PREFETCH_STATS_EN adds a saturating pop-while-empty counter output (underflow_cnt).
module vga_word_prefetch #(
    parameter logic [31:0] BASE_ADDR   = 32'h3E80,
    parameter int unsigned FRAME_WORDS = 384,
    parameter int unsigned DEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  VGA_state,
    input  logic        SRAM_busy,
    input  logic [31:0] SRAM_data_in,
    output logic        sram_req,
    output logic [31:0] sram_addr,
    input  logic        word_pop,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        underflow,
    output logic        frame_done
`ifdef PREFETCH_STATS_EN
    ,
    output logic [7:0]  underflow_cnt
`endif
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;
    localparam int unsigned CW   = $clog2(FRAME_WORDS + 1);
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);
    localparam logic [CW-1:0]   FRAME_C = CW'(FRAME_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CW-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;
    logic            underflow_q, underflow_d;
    logic            done_q, done_d;
    logic            rearm_q, rearm_d;

    logic complete, rearm_req, push, pop_ok, pop_empty, pending_busy;

    always_comb begin
        complete     = (state_q == S_FETCH) && req_q && !SRAM_busy;
        pending_busy = req_q && SRAM_busy;
        rearm_req    = (state_q == S_FETCH) && ((VGA_state == 2'd1) || rearm_q);
        // A completion that coincides with a re-arm is dropped; ARM flushes anyway.
        push         = complete && !rearm_req;
        pop_ok       = word_pop && (count_q != '0);
        pop_empty    = word_pop && (count_q == '0);

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fetch_cnt_d = fetch_cnt_q;
        req_d       = req_q;
        addr_d      = addr_q;
        underflow_d = underflow_q;
        done_d      = done_q;
        rearm_d     = rearm_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNTW'(push) - CNTW'(pop_ok);
        if (pop_empty) begin
            underflow_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (VGA_state == 2'd1) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                count_d     = '0;
                fetch_cnt_d = '0;
                addr_d      = BASE_ADDR;
                underflow_d = 1'b0;
                done_d      = 1'b0;
                rearm_d     = 1'b0;
                req_d       = (FRAME_WORDS != 0);
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                if (rearm_req) begin
                    if (pending_busy) begin
                        rearm_d = 1'b1;
                    end else begin
                        rearm_d = 1'b0;
                        req_d   = 1'b0;
                        state_d = S_ARM;
                    end
                end else begin
                    if (complete) begin
                        fetch_cnt_d = fetch_cnt_q + 1'b1;
                        addr_d      = addr_q + 32'd1;
                    end
                    // Next request looks at post-push/pop occupancy so a pop at full re-opens a slot at once.
                    if (!pending_busy) begin
                        req_d = (count_d < DEPTH_C) && (fetch_cnt_d < FRAME_C);
                    end
                    if ((fetch_cnt_q == FRAME_C) && !req_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (VGA_state == 2'd0) begin
                    state_d = S_IDLE;
                end else if (VGA_state == 2'd1) begin
                    state_d = S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fetch_cnt_q <= '0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
            rearm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fetch_cnt_q <= fetch_cnt_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            underflow_q <= underflow_d;
            done_q      <= done_d;
            rearm_q     <= rearm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= SRAM_data_in;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [7:0] ucnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ucnt_q <= '0;
        end else if (pop_empty && (ucnt_q != 8'hFF)) begin
            ucnt_q <= ucnt_q + 8'd1;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif

    assign sram_req   = req_q;
    assign sram_addr  = addr_q;
    assign word_valid = (count_q != '0);
    // Memory is not reset, so the head is masked to keep word_out at 0 while empty.
    assign word_out   = word_valid ? mem_q[rd_ptr_q] : '0;
    assign underflow  = underflow_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_vga_word_prefetch.sv
// Self-checking bench for vga_word_prefetch: cycle table for the fill/re-arm/underflow corners, scoreboard for a full frame.
module tb_vga_word_prefetch;

    localparam logic [31:0] BASE  = 32'h3E80;
    localparam int          FRAME = 384;
    localparam int          DEPTH = 4;
    localparam int          LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  vga = 2'd0;
    logic        busy = 1'b1;
    logic [31:0] sdata;
    logic        pop = 1'b0;
    logic        sram_req;
    logic [31:0] sram_addr;
    logic [31:0] word_out;
    logic        word_valid;
    logic        underflow;
    logic        frame_done;
`ifdef PREFETCH_STATS_EN
    logic [7:0]  ucnt;
`endif

    vga_word_prefetch #(
        .BASE_ADDR(BASE),
        .FRAME_WORDS(FRAME),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .VGA_state(vga),
        .SRAM_busy(busy),
        .SRAM_data_in(sdata),
        .sram_req(sram_req),
        .sram_addr(sram_addr),
        .word_pop(pop),
        .word_out(word_out),
        .word_valid(word_valid),
        .underflow(underflow),
        .frame_done(frame_done)
`ifdef PREFETCH_STATS_EN
        ,
        .underflow_cnt(ucnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dmodel(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // SRAM model answers whatever address is presented.
    assign sdata = dmodel(sram_addr);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  vga;
        logic        busy;
        logic        pop;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] word;
        logic        uf;
    } vec_t;

    vec_t vt[20];

    logic [31:0] sb[$];
    logic [31:0] exp_addr, last_addr, prev_addr, head;
    logic        prev_pending, b, p;
    int          nwords, cyc;

    initial begin
        vt[0]  = '{2'd1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0,                1'b0};
        vt[1]  = '{2'd2, 1'b0, 1'b0, 1'b1, 32'h3E80, 1'b0, 32'h0,                1'b0};
        vt[2]  = '{2'd2, 1'b0, 1'b0, 1'b1, 32'h3E81, 1'b1, dmodel(32'h3E80),     1'b0};
        vt[3]  = '{2'd2, 1'b0, 1'b0, 1'b1, 32'h3E82, 1'b1, dmodel(32'h3E80),     1'b0};
        vt[4]  = '{2'd2, 1'b0, 1'b0, 1'b1, 32'h3E83, 1'b1, dmodel(32'h3E80),     1'b0};
        vt[5]  = '{2'd2, 1'b0, 1'b0, 1'b0, 32'h3E84, 1'b1, dmodel(32'h3E80),     1'b0};
        vt[6]  = '{2'd2, 1'b0, 1'b1, 1'b1, 32'h3E84, 1'b1, dmodel(32'h3E81),     1'b0};
        vt[7]  = '{2'd2, 1'b1, 1'b0, 1'b1, 32'h3E84, 1'b1, dmodel(32'h3E81),     1'b0};
        vt[8]  = '{2'd2, 1'b0, 1'b1, 1'b1, 32'h3E85, 1'b1, dmodel(32'h3E82),     1'b0};
        vt[9]  = '{2'd2, 1'b1, 1'b0, 1'b1, 32'h3E85, 1'b1, dmodel(32'h3E82),     1'b0};
        vt[10] = '{2'd1, 1'b1, 1'b0, 1'b1, 32'h3E85, 1'b1, dmodel(32'h3E82),     1'b0};
        for (int i = 11; i < 15; i++) begin
            vt[i] = '{2'd2, 1'b1, 1'b0, 1'b1, 32'h3E85, 1'b1, dmodel(32'h3E82), 1'b0};
        end
        vt[15] = '{2'd2, 1'b0, 1'b0, 1'b0, 32'h3E85, 1'b1, dmodel(32'h3E82),     1'b0};
        vt[16] = '{2'd2, 1'b1, 1'b0, 1'b1, 32'h3E80, 1'b0, 32'h0,                1'b0};
        for (int i = 17; i < 20; i++) begin
            vt[i] = '{2'd2, 1'b1, 1'b1, 1'b1, 32'h3E80, 1'b0, 32'h0, 1'b1};
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req",   32'(sram_req),   32'd0);
        check("rst_addr",  sram_addr,       32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_req",  32'(sram_req),   32'd0);

        for (int i = 0; i < 20; i++) begin
            vga  = vt[i].vga;
            busy = vt[i].busy;
            pop  = vt[i].pop;
            tick();
            check($sformatf("r%0d_req", i),   32'(sram_req),   32'(vt[i].req));
            check($sformatf("r%0d_addr", i),  sram_addr,       vt[i].addr);
            check($sformatf("r%0d_valid", i), 32'(word_valid), 32'(vt[i].valid));
            check($sformatf("r%0d_word", i),  word_out,        vt[i].word);
            check($sformatf("r%0d_uf", i),    32'(underflow),  32'(vt[i].uf));
            check($sformatf("r%0d_done", i),  32'(frame_done), 32'd0);
        end
        pop = 1'b0;
`ifdef PREFETCH_STATS_EN
        check("ucnt_3", 32'(ucnt), 32'd3);
`endif

        // Reset mid-request: request pending with SRAM busy
        check("pre_rst_pending", 32'(sram_req), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_req",   32'(sram_req),   32'd0);
        check("mid_rst_addr",  sram_addr,       32'd0);
        check("mid_rst_valid", 32'(word_valid), 32'd0);
        check("mid_rst_uf",    32'(underflow),  32'd0);
`ifdef PREFETCH_STATS_EN
        check("mid_rst_ucnt",  32'(ucnt),       32'd0);
`endif
        rst  = 1'b0;
        busy = 1'b0;
        vga  = 2'd2;
        tick();
        tick();
        check("post_rst_req",   32'(sram_req),   32'd0);
        check("post_rst_valid", 32'(word_valid), 32'd0);

        // Full frame, one pop every 32 cycles
        vga  = 2'd1;
        busy = 1'b1;
        tick();
        vga = 2'd2;
        sb.delete();
        exp_addr     = BASE;
        last_addr    = '0;
        nwords       = 0;
        cyc          = 0;
        prev_pending = 1'b0;
        prev_addr    = '0;
        while (!frame_done && cyc < LIMIT) begin
            b = ($urandom_range(0, 3) == 0);
            p = ((cyc % 32) == 31) && word_valid;
            if (prev_pending) begin
                check("req_hold",  32'(sram_req), 32'd1);
                check("addr_hold", sram_addr,     prev_addr);
            end
            if (p) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'(sb.size()), 32'd1);
                end else begin
                    head = sb.pop_front();
                    check("frame_word", word_out, head);
                end
            end
            if (sram_req && !b) begin
                check("frame_addr", sram_addr, exp_addr);
                sb.push_back(dmodel(exp_addr));
                if (sb.size() > DEPTH) begin
                    check("fifo_occupancy", 32'(sb.size()), 32'(DEPTH));
                end
                last_addr = exp_addr;
                exp_addr  = exp_addr + 32'd1;
                nwords++;
            end
            prev_pending = sram_req && b;
            prev_addr    = sram_addr;
            busy = b;
            pop  = p;
            tick();
            cyc++;
        end
        pop  = 1'b0;
        busy = 1'b1;
        check("frame_timeout", 32'(frame_done), 32'd1);
        check("frame_words",   32'(nwords),     32'(FRAME));
        check("frame_last",    last_addr,       32'h3FFF);
        check("frame_req_off", 32'(sram_req),   32'd0);

        for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) begin
            if (!word_valid) begin
                check("drain_valid", 32'(word_valid), 32'd1);
                break;
            end
            head = sb.pop_front();
            check("drain_word", word_out, head);
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        check("drain_empty", 32'(word_valid), 32'd0);
        check("drain_sb",    32'(sb.size()),  32'd0);

        // DONE -> IDLE, then a fresh arm restarts from BASE
        vga = 2'd0;
        tick();
        vga = 2'd2;
        tick();
        check("idle2_req", 32'(sram_req), 32'd0);
        vga = 2'd1;
        tick();
        vga = 2'd2;
        tick();
        check("rearm_req",  32'(sram_req),   32'd1);
        check("rearm_addr", sram_addr,       BASE);
        check("rearm_done", 32'(frame_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
